// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, arbiter FSM states and datapath width.
package alu_arbiter_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_OR  = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response channels between the clients, the arbiter and the shared ALU.
interface alu_arbiter_if #(
  parameter int N_REQ = 4
);
  import alu_arbiter_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][ALU_W-1:0] req_a;
  logic [N_REQ-1:0][ALU_W-1:0] req_b;
  logic [N_REQ-1:0][1:0]       req_s;
  logic [N_REQ-1:0]            req_ready;

  logic [ALU_W-1:0]            alu_a;
  logic [ALU_W-1:0]            alu_b;
  alu_op_t                     alu_s;
  logic [ALU_W-1:0]            alu_y;

  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [ALU_W-1:0]            rsp_y;
  logic                        rsp_ready;

  // Environment side: clients, response consumer and the ALU itself.
  modport master (
    output req_valid, req_a, req_b, req_s, alu_y, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, req_s, alu_y, rsp_ready,
    output req_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_id, rsp_y
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr, wrapping past N_REQ-1.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_REQ) sum -= N_REQ;
    return ID_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path can infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    if (en) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && req[wrap_idx(ptr, i)]) begin
          any                     = 1'b1;
          idx                     = wrap_idx(ptr, i);
          grant[wrap_idx(ptr, i)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among N_REQ clients: grant, issue for one cycle, then hold
// the registered result on the response channel until it is taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  op_id;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] cur);
    return (int'(cur) == N_REQ - 1) ? '0 : cur + 1'b1;
  endfunction

  // Grants are only offered in IDLE, which keeps a single operation in flight.
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (state == IDLE),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign bus.req_ready = gnt;

  // The ALU operand registers double as the captured op, so they hold between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_id         <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_s     <= OP_NOT;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            bus.alu_a <= bus.req_a[gnt_idx];
            bus.alu_b <= bus.req_b[gnt_idx];
            bus.alu_s <= alu_op_t'(bus.req_s[gnt_idx]);
            op_id     <= gnt_idx;
            rr_ptr    <= next_ptr(gnt_idx);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          bus.rsp_y     <= bus.alu_y;
          bus.rsp_id    <= op_id;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
